// File: rtl/rs232_rx_sampler.sv
// RS-232 receive front end on the 4x baud clock: synchronizes rx, votes each
// bit from three mid-bit samples and reports good frames and framing errors.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | line idle, waiting for rx_s low (that cycle is phase 0)
// START     | validating start bit, false start returns to IDLE
// DATA      | voting data bits LSB first into the shift register
// STOP      | voting stop bit, good frame or framing error
// WAIT_IDLE | after a framing error, waiting for the line to go high
module rs232_rx_sampler #(
    parameter int DATA_BITS = 8,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clock_00_0384,
    input  logic                 reset_c,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_byte,
    output logic                 rx_valid,
    output logic                 framing_error,
    output logic [ERR_CNT_W-1:0] error_count,
    output logic                 busy
);

    localparam int BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_START     = 3'd1;
    localparam logic [2:0] ST_DATA      = 3'd2;
    localparam logic [2:0] ST_STOP      = 3'd3;
    localparam logic [2:0] ST_WAIT_IDLE = 3'd4;

    logic                 sync_1;
    logic                 rx_s;
    logic [2:0]           state;
    logic [2:0]           state_next;
    logic [1:0]           ph;
    logic [BIT_W-1:0]     bit_cnt;
    logic                 sample_1;
    logic                 sample_2;
    logic                 vote;
    logic                 bit_end;
    logic                 in_frame;
    logic                 frame_good;
    logic                 frame_bad;
    logic [DATA_BITS-1:0] shift_reg;
    logic [1:0]           valid_cnt;

    // Both stages reset high so leaving reset never looks like a start bit.
    always_ff @(posedge clock_00_0384 or posedge reset_c) begin
        if (reset_c) begin
            sync_1 <= 1'b1;
            rx_s   <= 1'b1;
        end else begin
            sync_1 <= rx;
            rx_s   <= sync_1;
        end
    end

    assign bit_end    = (ph == 2'd3);
    assign vote       = (sample_1 & sample_2) | (sample_1 & rx_s) | (sample_2 & rx_s);
    assign in_frame   = (state == ST_START) || (state == ST_DATA) || (state == ST_STOP);
    assign frame_good = (state == ST_STOP) && bit_end && vote;
    assign frame_bad  = (state == ST_STOP) && bit_end && !vote;

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (!rx_s) state_next = ST_START;
            end
            ST_START: begin
                if (bit_end) state_next = vote ? ST_IDLE : ST_DATA;
            end
            ST_DATA: begin
                if (bit_end && (bit_cnt == LAST_BIT)) state_next = ST_STOP;
            end
            ST_STOP: begin
                if (bit_end) state_next = vote ? ST_IDLE : ST_WAIT_IDLE;
            end
            ST_WAIT_IDLE: begin
                if (rx_s) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // busy covers the cycle after the stop vote, when state is already IDLE.
    always_ff @(posedge clock_00_0384 or posedge reset_c) begin
        if (reset_c) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= (state != ST_IDLE) || (state_next != ST_IDLE);
        end
    end

    always_ff @(posedge clock_00_0384 or posedge reset_c) begin
        if (reset_c) begin
            ph <= 2'd0;
        end else if (state == ST_IDLE) begin
            ph <= rx_s ? 2'd0 : 2'd1;
        end else if (state == ST_WAIT_IDLE) begin
            ph <= 2'd0;
        end else begin
            ph <= ph + 2'd1;
        end
    end

    always_ff @(posedge clock_00_0384 or posedge reset_c) begin
        if (reset_c) begin
            sample_1 <= 1'b1;
            sample_2 <= 1'b1;
        end else if (in_frame) begin
            if (ph == 2'd1) sample_1 <= rx_s;
            if (ph == 2'd2) sample_2 <= rx_s;
        end
    end

    always_ff @(posedge clock_00_0384 or posedge reset_c) begin
        if (reset_c) begin
            bit_cnt   <= '0;
            shift_reg <= '0;
        end else if (bit_end) begin
            if (state == ST_START) begin
                bit_cnt <= '0;
            end else if (state == ST_DATA) begin
                shift_reg[bit_cnt] <= vote;
                bit_cnt            <= bit_cnt + BIT_W'(1);
            end
        end
    end

    always_ff @(posedge clock_00_0384 or posedge reset_c) begin
        if (reset_c) begin
            rx_byte       <= '0;
            framing_error <= 1'b0;
            error_count   <= '0;
        end else begin
            framing_error <= frame_bad;
            if (frame_good) rx_byte <= shift_reg;
            if (frame_bad && (error_count != {ERR_CNT_W{1'b1}})) begin
                error_count <= error_count + ERR_CNT_W'(1);
            end
        end
    end

    // Valid window runs on its own so it may overlap the next frame's start.
    always_ff @(posedge clock_00_0384 or posedge reset_c) begin
        if (reset_c) begin
            rx_valid  <= 1'b0;
            valid_cnt <= 2'd0;
        end else if (frame_good) begin
            rx_valid  <= 1'b1;
            valid_cnt <= 2'd3;
        end else if (rx_valid) begin
            if (valid_cnt == 2'd0) begin
                rx_valid <= 1'b0;
            end else begin
                valid_cnt <= valid_cnt - 2'd1;
            end
        end
    end

endmodule
